// File: rtl/ntt_flat_pkg.sv
// ntt_flat_pkg
//   Shared constants and elaboration-time helpers for the flat forward NTT.
//   - N, D, Q, W, LOGD : coefficient width, transform length, prime modulus,
//                        primitive D-th root of unity, number of stages.
//   - pow_mod()        : modular exponentiation W-agnostic helper.
//   - twiddle(e)       : W^e mod Q, used to build per-butterfly constants.
//   - bit_rev(i)       : LOGD-bit reversal of an index (input reordering).
package ntt_flat_pkg;

    localparam int N    = 17;
    localparam int D    = 128;
    localparam int Q    = 65537;
    localparam int W    = 13987;
    localparam int LOGD = $clog2(D);

    // Square-and-multiply; only ever evaluated during elaboration.
    function automatic int unsigned pow_mod(input int unsigned base_in,
                                            input int unsigned e);
        longint unsigned acc;
        longint unsigned base;
        acc  = 1;
        base = longint'(base_in) % longint'(Q);
        for (int k = 0; k < 32; k++) begin
            if (e[k]) begin
                acc = (acc * base) % longint'(Q);
            end
            base = (base * base) % longint'(Q);
        end
        return int'(acc);
    endfunction

    function automatic int unsigned twiddle(input int unsigned e);
        return pow_mod(W, e);
    endfunction

    function automatic int unsigned bit_rev(input int unsigned i);
        int unsigned r;
        r = 0;
        for (int k = 0; k < LOGD; k++) begin
            r[LOGD-1-k] = i[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_flat_butterfly.sv
// ntt_butterfly
//   Combinational radix-2 Cooley-Tukey (DIT) butterfly over Z_Q, Q = 2^16+1.
//   Ports:
//     x   in  N  upper operand, < Q
//     y   in  N  lower operand, < Q
//     tw  in  N  twiddle factor, < Q
//     x_o out N  (x + y*tw) mod Q
//     y_o out N  (x - y*tw) mod Q
module ntt_butterfly
    import ntt_flat_pkg::*;
(
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] tw,
    output logic [N-1:0] x_o,
    output logic [N-1:0] y_o
);

    localparam logic        [N:0]   Q_ADD = (N+1)'(Q);
    localparam logic signed [N+1:0] Q_SUB = (N+2)'(Q);
    localparam logic signed [19:0]  Q_MUL = 20'(Q);

    // Product of two values <= 2^16 is at most 2^32, so hi fits in 18 bits.
    // Since 2^16 == -1 mod Q, p = hi*2^16 + lo == lo - hi; the difference is
    // in [-65536, 65535] and one conditional +Q lands it in [0, Q-1].
    function automatic logic [N-1:0] mul_mod(input logic [N-1:0] u,
                                             input logic [N-1:0] v);
        logic        [2*N-1:0] p;
        logic signed [19:0]    r;
        p = {{N{1'b0}}, u} * {{N{1'b0}}, v};
        r = $signed({4'b0000, p[15:0]}) - $signed({2'b00, p[33:16]});
        if (r < 0) begin
            r = r + Q_MUL;
        end
        return N'(r);
    endfunction

    function automatic logic [N-1:0] add_mod(input logic [N-1:0] u,
                                             input logic [N-1:0] v);
        logic [N:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= Q_ADD) begin
            s = s - Q_ADD;
        end
        return N'(s);
    endfunction

    function automatic logic [N-1:0] sub_mod(input logic [N-1:0] u,
                                             input logic [N-1:0] v);
        logic signed [N+1:0] d;
        d = $signed({2'b00, u}) - $signed({2'b00, v});
        if (d < 0) begin
            d = d + Q_SUB;
        end
        return N'(d);
    endfunction

    logic [N-1:0] t;

    always_comb begin
        t   = mul_mod(y, tw);
        x_o = add_mod(x, t);
        y_o = sub_mod(x, t);
    end

endmodule

// File: rtl/ntt_flat.sv
// ntt_flat
//   Fully parallel, fully pipelined forward cyclic NTT of D coefficients
//   over Z_Q. One vector in and one vector out per clock, latency LOGD+1.
//   Ports:
//     clk in  1    rising-edge clock
//     rst in  1    asynchronous active-high reset, clears every stage
//     a   in  D*N  input vector, coefficient j at a[N*j +: N] (may be >= Q)
//     b   out D*N  transformed vector, coefficient k at b[N*k +: N], < Q
//   Stage 0 registers the reduced input in bit-reversed order; stages
//   1..LOGD each register the output of one rank of D/2 butterflies, so the
//   result comes out in natural order.
module ntt_flat
    import ntt_flat_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [D*N-1:0] a,
    output logic [D*N-1:0] b
);

    localparam logic [N-1:0] Q_IN = N'(Q);

    // Input range is [0, 2^17), so a single subtraction is always enough.
    function automatic logic [N-1:0] reduce_in(input logic [N-1:0] v);
        return (v >= Q_IN) ? (v - Q_IN) : v;
    endfunction

    logic [N-1:0] stg_d [LOGD+1][D];
    logic [N-1:0] stg_q [LOGD+1][D];
    logic [N-1:0] bf_o  [LOGD][D];

    // Stage 0: reduce and bit-reverse the input, then collect butterfly ranks
    always_comb begin
        for (int j = 0; j < D; j++) begin
            stg_d[0][j] = reduce_in(a[N*bit_rev(j) +: N]);
        end
        for (int s = 0; s < LOGD; s++) begin
            for (int k = 0; k < D; k++) begin
                stg_d[s+1][k] = bf_o[s][k];
            end
        end
    end

    // Butterfly ranks: rank s pairs indices HALF apart inside blocks of
    // 2*HALF; the twiddle exponent is the position within the block scaled
    // by D/(2*HALF), so every twiddle is a constant folded at elaboration.
    for (genvar s = 0; s < LOGD; s++) begin : g_stage
        for (genvar bi = 0; bi < D/2; bi++) begin : g_bfly
            localparam int HALF = 1 << s;
            localparam int GRP  = bi / HALF;
            localparam int POS  = bi % HALF;
            localparam int IDX_X = GRP * 2 * HALF + POS;
            localparam int IDX_Y = IDX_X + HALF;
            localparam int EXP   = POS << (LOGD - 1 - s);
            localparam logic [N-1:0] TW = N'(twiddle(EXP));

            ntt_butterfly u_bfly (
                .x   (stg_q[s][IDX_X]),
                .y   (stg_q[s][IDX_Y]),
                .tw  (TW),
                .x_o (bf_o[s][IDX_X]),
                .y_o (bf_o[s][IDX_Y])
            );
        end
    end

    // Stage registers 0..LOGD; all of them clear on reset so no in-flight
    // vector survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= LOGD; s++) begin
                for (int k = 0; k < D; k++) begin
                    stg_q[s][k] <= '0;
                end
            end
        end else begin
            for (int s = 0; s <= LOGD; s++) begin
                for (int k = 0; k < D; k++) begin
                    stg_q[s][k] <= stg_d[s][k];
                end
            end
        end
    end

    // Output stage: last rank is already in natural order
    for (genvar k = 0; k < D; k++) begin : g_out
        assign b[N*k +: N] = stg_q[LOGD][k];
    end

endmodule

// File: tb/tb_ntt_flat.sv
module tb_ntt_flat;

    localparam int BN = 17;
    localparam int BD = 128;
    localparam longint unsigned BQ = 65537;
    localparam longint unsigned BW = 13987;

    typedef logic [BD*BN-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    vec_t a;
    vec_t b;

    always #5 clk = ~clk;

    ntt_flat dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b)
    );

    int total = 0;
    int bad   = 0;
    vec_t  exp_q[$];
    string tag_q[$];
    longint unsigned pw[BD];

    function automatic vec_t ref_ntt(input vec_t v);
        longint unsigned av[BD];
        longint unsigned acc;
        vec_t r;
        for (int j = 0; j < BD; j++) av[j] = longint'(v[BN*j +: BN]) % BQ;
        for (int k = 0; k < BD; k++) begin
            acc = 0;
            for (int j = 0; j < BD; j++) acc = (acc + av[j] * pw[(j*k) % BD]) % BQ;
            r[BN*k +: BN] = BN'(acc);
        end
        return r;
    endfunction

    function automatic int first_diff(input vec_t x, input vec_t y);
        for (int k = 0; k < BD; k++) if (x[BN*k +: BN] !== y[BN*k +: BN]) return k;
        return 0;
    endfunction

    function automatic vec_t rand_vec(input int n);
        vec_t v;
        for (int j = 0; j < BD; j++) begin
            case ((j + n) % 8)
                0:       v[BN*j +: BN] = BN'(65536);
                1:       v[BN*j +: BN] = BN'(65537 + $urandom_range(0, 65534));
                2:       v[BN*j +: BN] = BN'(131071);
                default: v[BN*j +: BN] = BN'($urandom_range(0, 131071));
            endcase
        end
        return v;
    endfunction

    task automatic check_vec(input string tag, input vec_t e);
        int i;
        i = first_diff(b, e);
        total++;
        assert (b === e) else begin
            bad++;
            $error("FAIL %s coef %0d got %0d want %0d", tag, i, b[BN*i +: BN], e[BN*i +: BN]);
        end
    endtask

    task automatic check_coef(input string tag, input int k, input int unsigned want);
        total++;
        assert (b[BN*k +: BN] === BN'(want)) else begin
            bad++;
            $error("FAIL %s got %0d want %0d", tag, b[BN*k +: BN], want);
        end
    endtask

    // Pipeline holds zeros after reset: the first 7 outputs after release are 0.
    task automatic prime();
        exp_q.delete();
        tag_q.delete();
        repeat (7) begin
            exp_q.push_back('0);
            tag_q.push_back("flush_zero");
        end
    endtask

    task automatic drive(input vec_t v, input vec_t e, input string tag);
        a = v;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step(input vec_t v, input vec_t e, input string tag);
        vec_t  ev;
        string et;
        @(posedge clk);
        #1;
        ev = exp_q.pop_front();
        et = tag_q.pop_front();
        check_vec(et, ev);
        if (et == "shift") begin
            check_coef("shift_b0", 0, 1);
            check_coef("shift_b1", 1, 13987);
            check_coef("shift_b64", 64, 65536);
        end
        drive(v, e, tag);
    endtask

    vec_t v_imp, e_imp, v_cst, e_cst, v_sh, e_sh, v;

    initial begin
        pw[0] = 1;
        for (int i = 1; i < BD; i++) pw[i] = (pw[i-1] * BW) % BQ;

        v_imp = '0; v_imp[0 +: BN] = 1;
        e_imp = '0; for (int k = 0; k < BD; k++) e_imp[BN*k +: BN] = 1;
        v_cst = '0; for (int k = 0; k < BD; k++) v_cst[BN*k +: BN] = 1;
        e_cst = '0; e_cst[0 +: BN] = 128;
        v_sh  = '0; v_sh[BN +: BN] = 1;
        e_sh  = '0; for (int k = 0; k < BD; k++) e_sh[BN*k +: BN] = BN'(pw[k]);

        // Reset held with arbitrary input
        rst = 1'b1;
        a   = rand_vec(0);
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_init", '0);
        a = rand_vec(3);
        @(posedge clk);
        #1;
        check_vec("rst_init_held", '0);

        // Release and run directed then random vectors back-to-back
        rst = 1'b0;
        prime();
        drive(v_imp, e_imp, "impulse");
        step(v_cst, e_cst, "constant");
        step(v_sh, e_sh, "shift");
        for (int n = 0; n < 12; n++) begin
            v = rand_vec(n);
            step(v, ref_ntt(v), "random");
        end

        // Reset mid-stream: in-flight vectors are discarded
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_vec("rst_async", '0);
        a = rand_vec(5);
        @(posedge clk);
        #1;
        check_vec("rst_mid_held", '0);
        rst = 1'b0;
        prime();
        v = rand_vec(7);
        drive(v, ref_ntt(v), "post_rst");
        for (int n = 0; n < 5; n++) begin
            v = rand_vec(n + 20);
            step(v, ref_ntt(v), "post_rst");
        end
        repeat (8) step('0, '0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
